// File: rtl/updown_load_counter.sv
// Parametrised up/down counter with load, programmable modulus, wrap/saturate and a registered terminal-count pulse.
// Optional feature: define COUNTER_AUTORELOAD_EN for a periodic down-timer that reloads from the last loaded value.
module updown_load_counter #(
  parameter int unsigned      WIDTH   = 8,
  parameter logic [WIDTH-1:0] MAX_VAL = {WIDTH{1'b1}},
  parameter bit               WRAP    = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  input  logic             up,
  output logic [WIDTH-1:0] count,
  output logic             zero,
  output logic             at_max,
  output logic             tc
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [WIDTH-1:0] load_clamped;
  logic [WIDTH-1:0] step_val;
  logic [WIDTH-1:0] terminal;
  logic             step_tc;

`ifdef COUNTER_AUTORELOAD_EN
  logic [WIDTH-1:0] reload_q;
`endif

  assign load_clamped = (load_val > MAX_VAL) ? MAX_VAL : load_val;
  assign terminal     = up ? MAX_VAL : '0;

  // NOTE: every signal driven in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    step_val = count;
    if (up) begin
      if (count != MAX_VAL) step_val = count + ONE;
      else if (WRAP)        step_val = '0;
    end else begin
      if (count != '0) step_val = count - ONE;
`ifdef COUNTER_AUTORELOAD_EN
      else             step_val = reload_q;
`else
      else if (WRAP)   step_val = MAX_VAL;
`endif
    end
  end

  // A hold (saturated or reload of 0) lands on the terminal value without moving, so it does not pulse.
  assign step_tc = (step_val == terminal) && (step_val != count);

  // NOTE: sequential state uses non-blocking assignments so all registers update together on the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
      tc    <= 1'b0;
`ifdef COUNTER_AUTORELOAD_EN
      reload_q <= '0;
`endif
    end else if (load) begin
      count <= load_clamped;
      tc    <= 1'b0;
`ifdef COUNTER_AUTORELOAD_EN
      reload_q <= load_clamped;
`endif
    end else if (en) begin
      count <= step_val;
      tc    <= step_tc;
    end else begin
      tc <= 1'b0;
    end
  end

  assign zero   = (count == '0);
  assign at_max = (count == MAX_VAL);

endmodule

// File: tb/tb_updown_load_counter.sv
// Self-checking bench: a wrapping and a saturating 0..9 counter driven by table vectors, hand sequences and random stimulus.
module tb_updown_load_counter;

  localparam int MAXV = 9;

  logic       clk = 1'b0;
  logic       rst, load, en, up;
  logic [3:0] load_val;
  logic [3:0] cnt_w, cnt_s;
  logic       zero_w, zero_s, at_max_w, at_max_s, tc_w, tc_s;

  int checks = 0;
  int errors = 0;

  // Reference state per instance: 0 = wrapping, 1 = saturating.
  int m_cnt[2];
  int m_rel[2];
  bit m_tc[2];

  always #5 clk = ~clk;

  updown_load_counter #(.WIDTH(4), .MAX_VAL(4'd9), .WRAP(1'b1)) dut_w (
    .clk(clk), .rst(rst), .load(load), .load_val(load_val), .en(en), .up(up),
    .count(cnt_w), .zero(zero_w), .at_max(at_max_w), .tc(tc_w)
  );

  updown_load_counter #(.WIDTH(4), .MAX_VAL(4'd9), .WRAP(1'b0)) dut_s (
    .clk(clk), .rst(rst), .load(load), .load_val(load_val), .en(en), .up(up),
    .count(cnt_s), .zero(zero_s), .at_max(at_max_s), .tc(tc_s)
  );

  typedef struct {
    bit r;
    bit l;
    int lv;
    bit e;
    bit u;
    int exp_count;
    bit exp_tc;
  } vec_t;

  vec_t tbl[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  // Counter semantics expressed as modular arithmetic on an integer in [0, MAXV].
  task automatic model_edge(input int k, input bit wrap);
    int nxt;
    if (rst) begin
      m_cnt[k] = 0; m_tc[k] = 0; m_rel[k] = 0;
    end else if (load) begin
      m_cnt[k] = (int'(load_val) > MAXV) ? MAXV : int'(load_val);
      m_rel[k] = m_cnt[k];
      m_tc[k]  = 0;
    end else if (en) begin
      if (up) begin
        if (wrap) nxt = (m_cnt[k] + 1) % (MAXV + 1);
        else      nxt = (m_cnt[k] + 1 > MAXV) ? MAXV : m_cnt[k] + 1;
      end else begin
`ifdef COUNTER_AUTORELOAD_EN
        if (m_cnt[k] == 0) nxt = m_rel[k];
        else               nxt = m_cnt[k] - 1;
`else
        if (wrap) nxt = (m_cnt[k] + MAXV) % (MAXV + 1);
        else      nxt = (m_cnt[k] == 0) ? 0 : m_cnt[k] - 1;
`endif
      end
      m_tc[k]  = (nxt == (up ? MAXV : 0)) && (nxt != m_cnt[k]);
      m_cnt[k] = nxt;
    end else begin
      m_tc[k] = 0;
    end
  endtask

  task automatic step(input bit r, input bit l, input int lv, input bit e, input bit u);
    @(negedge clk);
    rst = r; load = l; load_val = 4'(lv); en = e; up = u;
    @(posedge clk);
    model_edge(0, 1'b1);
    model_edge(1, 1'b0);
    #1;
    check("model_count_w", cnt_w, m_cnt[0]);
    check("model_tc_w", tc_w, m_tc[0]);
    check("model_zero_w", zero_w, m_cnt[0] == 0);
    check("model_at_max_w", at_max_w, m_cnt[0] == MAXV);
    check("model_count_s", cnt_s, m_cnt[1]);
    check("model_tc_s", tc_s, m_tc[1]);
    check("model_zero_s", zero_s, m_cnt[1] == 0);
    check("model_at_max_s", at_max_s, m_cnt[1] == MAXV);
  endtask

  task automatic add(input bit r, l, input int lv, input bit e, u, input int ec, input bit et);
    vec_t v;
    v.r = r; v.l = l; v.lv = lv; v.e = e; v.u = u; v.exp_count = ec; v.exp_tc = et;
    tbl.push_back(v);
  endtask

  initial begin
    rst = 1'b1; load = 1'b0; load_val = '0; en = 1'b0; up = 1'b0;
    m_cnt = '{0, 0}; m_rel = '{0, 0}; m_tc = '{0, 0};

    // Vectors for the wrapping instance.
    add(1, 0, 0, 0, 0, 0, 0);
    add(1, 0, 0, 0, 0, 0, 0);
    for (int i = 1; i <= 12; i++) add(0, 0, 0, 1, 1, i % 10, i == 9);
    add(0, 1, 15, 0, 0, 9, 0);
    for (int i = 1; i <= 11; i++) add(0, 0, 0, 1, 0, (19 - i) % 10, i == 9);
    add(0, 1, 3, 1, 1, 3, 0);
    add(1, 1, 7, 1, 1, 0, 0);
    add(0, 1, 10, 0, 0, 9, 0);
    add(0, 0, 0, 0, 1, 9, 0);
    add(0, 1, 5, 0, 0, 5, 0);
    add(0, 0, 0, 1, 1, 6, 0);
    add(0, 0, 0, 1, 0, 5, 0);
    add(0, 0, 0, 1, 1, 6, 0);
    add(0, 0, 0, 1, 0, 5, 0);

    foreach (tbl[i]) begin
      step(tbl[i].r, tbl[i].l, tbl[i].lv, tbl[i].e, tbl[i].u);
      check("tbl_count", cnt_w, tbl[i].exp_count);
      check("tbl_tc", tc_w, tbl[i].exp_tc);
      check("tbl_zero", zero_w, tbl[i].exp_count == 0);
      check("tbl_at_max", at_max_w, tbl[i].exp_count == MAXV);
    end

`ifdef COUNTER_AUTORELOAD_EN
    // Periodic down-timer of period reload+1.
    step(0, 1, 3, 0, 0);
    for (int i = 0; i < 9; i++) begin
      int exp_c;
      exp_c = (i % 4 < 3) ? 2 - (i % 4) : 3;
      step(0, 0, 0, 1, 0);
      check("reload_count", cnt_w, exp_c);
      check("reload_tc", tc_w, exp_c == 0);
    end
    // A reload value of 0 parks at 0 without re-pulsing.
    step(0, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 1, 0);
      check("reload0_count", cnt_w, 0);
      check("reload0_tc", tc_w, 0);
    end
`else
    // Saturating instance: stop at zero, then climb to MAX and hold.
    step(0, 1, 2, 0, 0);
    for (int i = 1; i <= 5; i++) begin
      step(0, 0, 0, 1, 0);
      check("sat_down_count", cnt_s, (i == 1) ? 1 : 0);
      check("sat_down_tc", tc_s, i == 2);
    end
    for (int i = 1; i <= 11; i++) begin
      step(0, 0, 0, 1, 1);
      check("sat_up_count", cnt_s, (i > 9) ? 9 : i);
      check("sat_up_tc", tc_s, i == 9);
    end
`endif

    // Reset mid-count overrides everything and clears tc.
    step(0, 1, 8, 0, 0);
    step(0, 0, 0, 1, 1);
    step(1, 1, 4, 1, 1);
    check("mid_rst_count", cnt_w, 0);
    check("mid_rst_tc", tc_w, 0);

    for (int i = 0; i < 2000; i++) begin
      step($urandom_range(0, 49) == 0, $urandom_range(0, 9) == 0,
           int'($urandom_range(0, 15)), $urandom_range(0, 9) < 7, $urandom_range(0, 1) == 1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
